// File: rtl/pulse_period_monitor.sv
// Receive-side checker for single-cycle periodic pulse trains: measures event-to-event
// distance, reports each period, tracks lock against EXP_PERIOD and flags errors/timeouts.
module pulse_period_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int LOCK_COUNT = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             err_period,
    output logic             err_timeout
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [MATCH_W-1:0] match_cnt, match_nxt;
    logic [CNT_W-1:0]   period_nxt;
    logic               pulse_d;
    logic               valid_nxt, err_period_nxt, err_timeout_nxt;

    logic               evt;
    logic [CNT_W-1:0]   p_meas;
    logic               is_exp;
    logic               timeout_hit;

    assign evt         = pulse_in & ~pulse_d;
    assign p_meas      = cnt + 1'b1;
    assign is_exp      = (p_meas == CNT_W'(EXP_PERIOD));
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    assign locked      = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            pulse_d      <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
            err_period   <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            match_cnt    <= match_nxt;
            pulse_d      <= pulse_in;
            period_out   <= period_nxt;
            period_valid <= valid_nxt;
            err_period   <= err_period_nxt;
            err_timeout  <= err_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        match_nxt       = match_cnt;
        period_nxt      = period_out;
        valid_nxt       = 1'b0;
        err_period_nxt  = 1'b0;
        err_timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (evt) begin
                    state_nxt = ACQUIRE;
                    match_nxt = '0;
                end
            end
            ACQUIRE: begin
                // An event on the last counting cycle is a valid measurement, not a timeout
                if (evt) begin
                    cnt_nxt    = '0;
                    valid_nxt  = 1'b1;
                    period_nxt = p_meas;
                    if (is_exp) begin
                        match_nxt = match_cnt + 1'b1;
                        if (match_cnt + 1'b1 == MATCH_W'(LOCK_COUNT))
                            state_nxt = LOCKED;
                    end else begin
                        match_nxt = '0;
                    end
                end else if (timeout_hit) begin
                    state_nxt       = IDLE;
                    cnt_nxt         = '0;
                    match_nxt       = '0;
                    err_timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (evt) begin
                    cnt_nxt    = '0;
                    valid_nxt  = 1'b1;
                    period_nxt = p_meas;
                    if (!is_exp) begin
                        state_nxt      = ACQUIRE;
                        match_nxt      = '0;
                        err_period_nxt = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nxt       = IDLE;
                    cnt_nxt         = '0;
                    match_nxt       = '0;
                    err_timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                match_nxt = '0;
            end
        endcase
    end

endmodule
